// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver with scan-code decode, ASCII translation and a CPU-readable FIFO.
// Optional macro KBD_SHIFT_EN adds shift tracking (lowercase letters, shifted digit symbols).
module ps2_keyboard_fifo #(
  parameter logic [13:0] BASE_ADDRESS   = 14'h2500,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TIMEOUT_CYCLES = 50000
) (
  input  logic        system_clk,
  input  logic        reset,
  input  logic [13:0] address,
  input  logic        read,
  input  logic        PS2_clk,
  input  logic        PS2_data,
  output logic [63:0] data,
  output logic        char_available
);
  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [13:0] STAT_ADDR = BASE_ADDRESS + 14'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;

  logic r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2;
  logic w_fall;
  logic [3:0]    r_bit_cnt;
  logic [10:0]   r_frame;
  logic          r_frame_done, w_frame_ok;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_byte;
  logic          r_byte_vld;
  state_t        r_state;
  logic          w_lower, w_sym;
  logic [8:0]    w_xlate;
  logic          w_push, w_do_push, w_do_pop;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [7:0]    r_count, w_count_next, w_head, w_err_base;
  logic          r_overflow, r_frame_err;
  logic [7:0]    r_err_count;
  logic          w_hit_data, w_hit_stat, r_hit_data_prev, r_hit_stat_prev;
  logic          w_pop_req, w_clr;

  always_ff @(posedge system_clk) begin
    if (reset) begin
      {r_clk_s1, r_clk_s2, r_clk_prev, r_dat_s1, r_dat_s2} <= 5'b11111;
    end else begin
      r_clk_s1   <= PS2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= PS2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_prev & ~r_clk_s2;

  // Frame bits shift in from the top so that bit 0 (start) lands in r_frame[0].
  always_ff @(posedge system_clk) begin
    if (reset) begin
      r_bit_cnt    <= 4'd0;
      r_frame      <= 11'd0;
      r_frame_done <= 1'b0;
      r_timer      <= '0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_fall) begin
        r_frame <= {r_dat_s2, r_frame[10:1]};
        r_timer <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt    <= 4'd0;
          r_frame_done <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
          r_bit_cnt <= 4'd0;
          r_timer   <= '0;
        end else begin
          r_timer <= r_timer + 1'b1;
        end
      end
    end
  end

  assign w_frame_ok = ~r_frame[0] & (^r_frame[9:1]) & r_frame[10];

  always_ff @(posedge system_clk) begin
    if (reset) begin
      r_byte_vld <= 1'b0;
      r_byte     <= 8'd0;
    end else begin
      r_byte_vld <= r_frame_done & w_frame_ok;
      r_byte     <= r_frame[8:1];
    end
  end

  function automatic logic [8:0] translate(input logic [7:0] code, input logic lower,
                                           input logic sym);
    logic [7:0] letter;
    logic [3:0] digit;
    logic       is_digit;
    logic [8:0] res;
    letter = 8'h00; digit = 4'd0; is_digit = 1'b0; res = {1'b1, 8'h3F};
    case (code)
      8'h1C: letter = 8'h41;  8'h32: letter = 8'h42;  8'h21: letter = 8'h43;  8'h23: letter = 8'h44;
      8'h24: letter = 8'h45;  8'h2B: letter = 8'h46;  8'h34: letter = 8'h47;  8'h33: letter = 8'h48;
      8'h43: letter = 8'h49;  8'h3B: letter = 8'h4A;  8'h42: letter = 8'h4B;  8'h4B: letter = 8'h4C;
      8'h3A: letter = 8'h4D;  8'h31: letter = 8'h4E;  8'h44: letter = 8'h4F;  8'h4D: letter = 8'h50;
      8'h15: letter = 8'h51;  8'h2D: letter = 8'h52;  8'h1B: letter = 8'h53;  8'h2C: letter = 8'h54;
      8'h3C: letter = 8'h55;  8'h2A: letter = 8'h56;  8'h1D: letter = 8'h57;  8'h22: letter = 8'h58;
      8'h35: letter = 8'h59;  8'h1A: letter = 8'h5A;
      8'h45: {is_digit, digit} = {1'b1, 4'd0};  8'h16: {is_digit, digit} = {1'b1, 4'd1};
      8'h1E: {is_digit, digit} = {1'b1, 4'd2};  8'h26: {is_digit, digit} = {1'b1, 4'd3};
      8'h25: {is_digit, digit} = {1'b1, 4'd4};  8'h2E: {is_digit, digit} = {1'b1, 4'd5};
      8'h36: {is_digit, digit} = {1'b1, 4'd6};  8'h3D: {is_digit, digit} = {1'b1, 4'd7};
      8'h3E: {is_digit, digit} = {1'b1, 4'd8};  8'h46: {is_digit, digit} = {1'b1, 4'd9};
      8'h29: res = {1'b1, 8'h20};
      8'h5A: res = {1'b1, 8'h0D};
      8'h66: res = {1'b1, 8'h08};
      8'h12, 8'h59: res = 9'd0;
      default: ;
    endcase
    if (letter != 8'h00) begin
      res = {1'b1, lower ? (letter | 8'h20) : letter};
    end else if (is_digit) begin
      res = {1'b1, 8'h30 | {4'd0, digit}};
      if (sym) begin
        case (digit)
          4'd1: res[7:0] = 8'h21;  4'd2: res[7:0] = 8'h40;  4'd3: res[7:0] = 8'h23;
          4'd4: res[7:0] = 8'h24;  4'd5: res[7:0] = 8'h25;  4'd6: res[7:0] = 8'h5E;
          4'd7: res[7:0] = 8'h26;  4'd8: res[7:0] = 8'h2A;  4'd9: res[7:0] = 8'h28;
          default: res[7:0] = 8'h29;
        endcase
      end
    end
    return res;
  endfunction

`ifdef KBD_SHIFT_EN
  logic r_lshift, r_rshift;
  assign w_lower = ~(r_lshift | r_rshift);
  assign w_sym   = r_lshift | r_rshift;
`else
  assign w_lower = 1'b0;
  assign w_sym   = 1'b0;
`endif

  always_ff @(posedge system_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
`ifdef KBD_SHIFT_EN
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
`endif
    end else if (r_byte_vld) begin
      case (r_state)
        ST_IDLE: begin
          if (r_byte == 8'hF0)      r_state <= ST_BRK;
          else if (r_byte == 8'hE0) r_state <= ST_EXT;
`ifdef KBD_SHIFT_EN
          if (r_byte == 8'h12) r_lshift <= 1'b1;
          if (r_byte == 8'h59) r_rshift <= 1'b1;
`endif
        end
        ST_BRK: begin
          r_state <= ST_IDLE;
`ifdef KBD_SHIFT_EN
          if (r_byte == 8'h12) r_lshift <= 1'b0;
          if (r_byte == 8'h59) r_rshift <= 1'b0;
`endif
        end
        ST_EXT:  r_state <= (r_byte == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_xlate = translate(r_byte, w_lower, w_sym);
  assign w_push  = r_byte_vld && (r_state == ST_IDLE) && (r_byte != 8'hF0) &&
                   (r_byte != 8'hE0) && w_xlate[8];

  assign w_hit_data   = read && (address == BASE_ADDRESS);
  assign w_hit_stat   = read && (address == STAT_ADDR);
  assign w_pop_req    = w_hit_data & ~r_hit_data_prev;
  assign w_clr        = w_hit_stat & ~r_hit_stat_prev;
  // A pop on a full FIFO frees the slot the simultaneous push needs.
  assign w_do_pop     = w_pop_req && (r_count != 8'd0);
  assign w_do_push    = w_push && ((r_count != 8'(FIFO_DEPTH)) || w_do_pop);
  assign w_count_next = r_count + {7'd0, w_do_push} - {7'd0, w_do_pop};
  assign w_err_base   = w_clr ? 8'd0 : r_err_count;

  always_ff @(posedge system_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= w_xlate[7:0];
  end

  always_ff @(posedge system_clk) begin
    if (reset) begin
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= 8'd0; char_available <= 1'b0;
      r_overflow <= 1'b0; r_frame_err <= 1'b0; r_err_count <= 8'd0;
      r_hit_data_prev <= 1'b0; r_hit_stat_prev <= 1'b0;
    end else begin
      r_hit_data_prev <= w_hit_data;
      r_hit_stat_prev <= w_hit_stat;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count        <= w_count_next;
      char_available <= (w_count_next != 8'd0);
      r_overflow  <= (r_overflow & ~w_clr) | (w_push & ~w_do_push);
      r_frame_err <= (r_frame_err & ~w_clr) | (r_frame_done & ~w_frame_ok);
      if (r_frame_done && !w_frame_ok)
        r_err_count <= (w_err_base == 8'hFF) ? 8'hFF : w_err_base + 8'd1;
      else
        r_err_count <= w_err_base;
    end
  end

  assign w_head = (r_count != 8'd0) ? r_mem[r_rd_ptr] : 8'h00;
  assign data = w_hit_data ? {55'd0, (r_count != 8'd0), w_head} :
                w_hit_stat ? {40'd0, r_err_count, 6'd0, r_overflow, r_frame_err, r_count} :
                64'bz;
endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Randomised bench for ps2_keyboard_fifo: PS/2 frames and bus reads checked against a
// queue-based reference model of the keyboard decode rules.
module tb_ps2_keyboard_fifo;
  localparam logic [13:0] BASE  = 14'h2500;
  localparam int          DEPTH = 8;
  localparam int          TMO   = 300;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic [13:0] address = 14'd0;
  logic        read = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  wire  [63:0] data;
  logic        char_available;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [7:0] q[$];
  int         m_errc = 0;
  bit         m_ferr = 0, m_ovf = 0, m_brk = 0, m_ext = 0, m_lsh = 0, m_rsh = 0;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};
  string sym_str = ")!@#$%^&*(";

  ps2_keyboard_fifo #(.BASE_ADDRESS(BASE), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .system_clk(clk), .reset(srst), .address(address), .read(read),
    .PS2_clk(ps2_clk), .PS2_data(ps2_data), .data(data), .char_available(char_available));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("  ok   %-14s %h", tag, got);
    end
  endtask

  function automatic int xlate(input logic [7:0] b);
    bit sh;
    sh = m_lsh | m_rsh;
    foreach (letter_codes[i])
      if (letter_codes[i] == b) begin
`ifdef KBD_SHIFT_EN
        return sh ? 65 + i : 97 + i;
`else
        return 65 + i;
`endif
      end
    foreach (digit_codes[i])
      if (digit_codes[i] == b) return sh ? int'(sym_str[i]) : 48 + i;
    if (b == 8'h29) return 32;
    if (b == 8'h5A) return 13;
    if (b == 8'h66) return 8;
    if (b == 8'h12 || b == 8'h59) return -1;
    return 63;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit ok);
    int c;
    if (!ok) begin
      m_ferr = 1;
      if (m_errc < 255) m_errc++;
      return;
    end
    if (m_brk) begin
`ifdef KBD_SHIFT_EN
      if (!m_ext && b == 8'h12) m_lsh = 0;
      if (!m_ext && b == 8'h59) m_rsh = 0;
`endif
      m_brk = 0; m_ext = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1; else m_ext = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else begin
`ifdef KBD_SHIFT_EN
      if (b == 8'h12) m_lsh = 1;
      if (b == 8'h59) m_rsh = 1;
`endif
      c = xlate(b);
      if (c >= 0) begin
        if (q.size() == DEPTH) m_ovf = 1;
        else q.push_back(8'(c));
      end
    end
  endfunction

  // mode 0 good, 1 bad parity, 2 bad stop, 3 bad start; nbits < 11 sends a truncated frame
  task automatic send_frame(input logic [7:0] b, input int mode, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, ~^b, b, 1'b0};
    if (mode == 1) bits[9]  = ~bits[9];
    if (mode == 2) bits[10] = 1'b0;
    if (mode == 3) bits[0]  = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = bits[i];
      repeat (3) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (6) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (3) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    if (nbits == 11) model_byte(b, mode == 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 0, 11);
  endtask

  task automatic bus_read(input logic [13:0] addr, input int hold, output logic [63:0] v);
    @(negedge clk);
    address = addr;
    read = 1'b1;
    #1 v = data;
    repeat (hold) @(negedge clk);
    read = 1'b0;
    address = 14'd0;
  endtask

  task automatic check_data_read(input string tag, input int hold);
    logic [63:0] v, exp;
    exp = (q.size() != 0) ? {55'd0, 1'b1, q[0]} : 64'd0;
    bus_read(BASE, hold, v);
    check_eq(tag, v, exp);
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic check_status(input string tag);
    logic [63:0] v, exp;
    exp = {40'd0, 8'(m_errc), 6'd0, m_ovf, m_ferr, 8'(q.size())};
    bus_read(BASE + 14'd1, 1, v);
    check_eq(tag, v, exp);
    m_errc = 0; m_ferr = 0; m_ovf = 0;
  endtask

  task automatic check_avail(input string tag);
    @(negedge clk);
    check_eq(tag, {63'd0, char_available}, {63'd0, q.size() != 0});
  endtask

  initial begin
    logic [63:0] v;
    int r;
    logic [7:0] b;
    repeat (5) @(negedge clk);
    srst = 1'b0;
    repeat (2) @(negedge clk);

    check_avail("rst_avail");
    check_status("rst_status");
    check_data_read("rst_data", 1);

    // single key with break: push 'A', then empty again
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    check_avail("single_avail");
    bus_read(BASE, 1, v);
    check_eq("single_lit", v, 64'h141);
    void'(q.pop_front());
    check_data_read("single_empty", 1);
    check_avail("single_avail0");

    // bad parity frame, then a status read clears the sticky flags
    send_frame(8'h16, 1, 11);
    check_status("badpar_stat");
    check_status("badpar_clr");
    check_avail("badpar_avail");

    // overflow: nine distinct letters into an eight-deep queue
    for (int i = 0; i < 9; i++) send_byte(letter_codes[i]);
    check_status("ovf_stat");
    for (int i = 0; i < 8; i++) check_data_read($sformatf("ovf_rd%0d", i), 1);
    check_avail("ovf_avail0");

    // extended code, truncated frame left to time out, then digit '0'
    send_byte(8'hE0); send_byte(8'h75);
    send_frame(8'h45, 0, 4);
    repeat (TMO + 40) @(negedge clk);
    send_byte(8'h45);
    check_status("tmo_stat");
    check_data_read("tmo_data", 1);

    // shift handling
    send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12); send_byte(8'h1C);
    check_data_read("shift_rd0", 1);
    check_data_read("shift_rd1", 1);

    // held read pops once
    send_byte(8'h29); send_byte(8'h5A); send_byte(8'h66);
    check_data_read("held_rd", 5);
    check_status("held_stat");
    check_data_read("held_next", 1);
    check_data_read("held_last", 1);

    // randomised traffic
    for (int it = 0; it < 120; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: send_byte(letter_codes[$urandom_range(0, 25)]);
        4: send_byte(digit_codes[$urandom_range(0, 9)]);
        5: begin
          b = 8'h29;
          case ($urandom_range(0, 4))
            0: b = 8'h29; 1: b = 8'h5A; 2: b = 8'h66; 3: b = 8'h12; default: b = 8'h59;
          endcase
          send_byte(b);
        end
        6: send_byte(8'hF0);
        7: send_byte(8'hE0);
        8: send_byte(8'($urandom_range(0, 255)));
        default: send_frame(8'($urandom_range(0, 255)), $urandom_range(1, 3), 11);
      endcase
      check_avail($sformatf("rnd_av%0d", it));
      r = $urandom_range(0, 7);
      if (r < 3) check_data_read($sformatf("rnd_rd%0d", it), $urandom_range(1, 4));
      else if (r == 3) check_status($sformatf("rnd_st%0d", it));
    end
    check_status("final_stat");
    while (q.size() != 0) check_data_read("drain", 1);
    check_data_read("drain_empty", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_fifo.md
# ps2_keyboard_fifo

Memory-mapped PS/2 keyboard receiver for the system bus, sitting alongside VRAM-space peripherals at a parametrised base address. It samples the PS/2 clock and data lines in the `system_clk` domain and validates each 11-bit frame: start bit, odd parity and stop bit. It decodes make, break and extended prefixes, translates make codes to ASCII, and queues characters in a parametrised FIFO. The CPU pops characters through a data register and checks occupancy and errors through a status register.

## Interface
- `BASE_ADDRESS`, 14'h2500: data register address; status register is `BASE_ADDRESS+1`.
- `FIFO_DEPTH`, 8: character queue depth; power of two, 2..128.
- `TIMEOUT_CYCLES`, 50000: `system_clk` cycles without a PS/2 falling edge before a partial frame is discarded.
- `system_clk` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `address` in 14: bus address.
- `read` in 1: bus read strobe, level.
- `PS2_clk` in 1: asynchronous keyboard clock.
- `PS2_data` in 1: asynchronous keyboard data.
- `data` out 64: tri-state read bus; driven only on a register hit, otherwise 64'bz.
- `char_available` out 1: FIFO non-empty, registered.

## Operation
- **Input synchronisation:** `PS2_clk` and `PS2_data` each pass through a 2-flop synchroniser.
- **Edge strobe:** a falling-edge strobe fires when the previous synchronised clock is 1 and the current one is 0. Data is sampled in that cycle.
- **Frame assembler:**
  - Bit counter runs 0..10. Bit 0 is the start bit and must be 0.
  - Bits 1–8 are data, LSB first.
  - Bit 9 is parity: XOR of the 8 data bits and the parity bit must equal 1.
  - Bit 10 is the stop bit and must be 1.
  - Any violation discards the byte, sets sticky `frame_err`, and saturating-increments `err_count` (8 bits). The counter returns to 0 after bit 10 regardless of outcome.
- **Timeout:** while the bit counter ≠ 0, a timer counts cycles since the last strobe. Reaching `TIMEOUT_CYCLES` resets the counter to 0, with no error flagged.
- **Decoder FSM states:** IDLE, BRK, EXT, EXT_BRK.
  - IDLE: 0xF0 → BRK; 0xE0 → EXT; any other byte is a make code, handled below, and the FSM stays in IDLE.
  - BRK: next byte is a break code → IDLE; no push.
  - EXT: 0xF0 → EXT_BRK; any other byte → IDLE; no push.
  - EXT_BRK: next byte → IDLE; no push.
- **Make-code translation (IDLE only):**
  - Scan set 2 digits 0–9 and letters A–Z map to ASCII (e.g. 0x1C→'A' 0x41, 0x45→'0' 0x30).
  - 0x29→space 0x20; 0x5A→CR 0x0D; 0x66→BS 0x08.
  - Shift codes 0x12 and 0x59 are never pushed.
  - All other make codes push '?' 0x3F.
- **FIFO pushes:** a push when full drops the new character and sets sticky `overflow`.
- **Data register (`BASE_ADDRESS`):**
  - `data` = {55'b0, nonempty, head_ascii[7:0]}; head is 0x00 when empty.
  - Pop occurs once per read hit, on the first cycle of the hit (rising edge of registered hit). A read held for several cycles pops exactly once.
- **Status register (`BASE_ADDRESS+1`):**
  - `data` = {40'b0, err_count[7:0], 6'b0, overflow, frame_err, count[7:0]}.
  - First cycle of a status hit clears `overflow`, `frame_err` and `err_count` at the clock edge. The read returns pre-clear values.
- **Simultaneous push and pop:**
  - Full: pop, then push accepted; count unchanged; no overflow.
  - Empty: pop ignored, push accepted.
- **Reset:**
  - FIFO empty, pointers 0, `char_available`=0.
  - FSM IDLE, bit counter 0, timer 0, sticky flags 0, `err_count` 0.
  - Shift state cleared.
  - Synchroniser flops reset to 1 (idle line).
  - Reset mid-frame or mid-read discards everything in flight.

## Timing
- **Decode pipeline:** let E be the cycle with the stop-bit strobe. Byte is validated at E+1, decoded and pushed at E+2, and readable on `data` and `char_available` from E+3.
- **Pin latency:** pin edge to strobe is 2–3 cycles (synchroniser).
- **Bus read path:** `data` is combinational from `address`, `read` and registered state; valid in the same cycle as the hit.
- **Pop latency:** the pop takes effect at the end of the first hit cycle; the next head is visible on the following hit.

## Configuration
- **`KBD_SHIFT_EN` defined:**
  - Make 0x12/0x59 sets a per-key shift bit; the matching break clears it.
  - Letters push lowercase (0x61–0x7A) when no shift bit is set, uppercase when either is set.
  - Shifted digits push US-layout symbols (1→'!', 2→'@', …, 0→')').
- **`KBD_SHIFT_EN` undefined:** no shift state; letters always uppercase, digits unshifted; shift codes still never pushed.

## Test plan
- **Single key:** frame 0x1C with parity 0, then F0 1C → `char_available`=1; data read = 0x...0141; second read = 0x...0000, `char_available`=0.
- **Bad frame:** frame 0x16 with wrong parity → no push; status read = `frame_err`=1, `err_count`=1; next status read = all zero.
- **Overflow:** 9 distinct make codes with `FIFO_DEPTH`=8 → count=8, `overflow`=1; reads return the first 8 characters in order.
- **Extended and timeout:** E0 75 (arrow) → no push. Then 4 bits of a frame, idle for `TIMEOUT_CYCLES`, then full frame 0x45 → pushes 0x30, no error.
- **Shift (`KBD_SHIFT_EN`):** 12, 1C, F0 1C, F0 12, 1C → pushes 0x41 then 0x61. Without the macro → 0x41, 0x41.
- **Held read:** read held 5 cycles on `BASE_ADDRESS` with 3 queued characters → exactly one pop; count goes 3→2.
